// File: rtl/seven_seg_scan_decoder_pkg.sv
// seven_seg_pkg: shared constants for the 4-digit 7-segment scan decoder.
//   - SEG_0 .. SEG_F : active-low segment glyphs, bit6 = a .. bit0 = g
//   - AN_BLANK       : anode pattern with every digit disabled
//   - state_t        : frame-collection FSM encoding
//   - an_is_onehot_low / an_index : anode classification helpers
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [3:0] AN_BLANK = 4'hF;

    typedef enum logic [1:0] {
        S_SYNC    = 2'd0,
        S_COLLECT = 2'd1,
        S_STALL   = 2'd2
    } state_t;

    // Exactly one anode driven low selects a single digit.
    function automatic logic an_is_onehot_low(input logic [3:0] an);
        logic r;
        case (an)
            4'hE, 4'hD, 4'hB, 4'h7: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Digit index of a one-hot-low anode pattern (0 for anything else).
    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] r;
        case (an)
            4'hD:    r = 2'd1;
            4'hB:    r = 2'd2;
            4'h7:    r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// seven_seg_scan_decoder_if: bundle of the scanned display bus and the
// decoded results.
//   Anode_Activate[3:0] : active-low digit enables (bus side)
//   LED_out[6:0]        : active-low segments, bit6 = a .. bit0 = g
//   err_clr             : one-cycle pulse clearing anode_err
//   digits[15:0]        : {d3,d2,d1,d0}
//   digit_valid[3:0]    : last accepted glyph per digit was legal
//   frame_valid         : one-cycle pulse per completed 4-digit frame
//   anode_err           : sticky multi-anode error
//   scan_stalled        : no digit accepted for the timeout period
// master drives the bus and observes results; slave is the decoder.
interface seven_seg_scan_decoder_if;
    logic [3:0]  Anode_Activate;
    logic [6:0]  LED_out;
    logic        err_clr;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        anode_err;
    logic        scan_stalled;

    modport master (
        output Anode_Activate, LED_out, err_clr,
        input  digits, digit_valid, frame_valid, anode_err, scan_stalled
    );

    modport slave (
        input  Anode_Activate, LED_out, err_clr,
        output digits, digit_valid, frame_valid, anode_err, scan_stalled
    );
endinterface

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational active-low 7-segment pattern -> {valid,value}.
//   seg[6:0]   in  : active-low segments, bit6 = a .. bit0 = g
//   valid      out : pattern is a legal glyph
//   value[3:0] out : decoded value, 4'hF for an unrecognised pattern
// Build option HEX_DECODE_EN: also accept the A,b,C,d,E,F glyphs.
module seg7_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] value
);

    always_comb begin
        valid = 1'b1;
        value = 4'h0;
        case (seg)
            SEG_0: value = 4'h0;
            SEG_1: value = 4'h1;
            SEG_2: value = 4'h2;
            SEG_3: value = 4'h3;
            SEG_4: value = 4'h4;
            SEG_5: value = 4'h5;
            SEG_6: value = 4'h6;
            SEG_7: value = 4'h7;
            SEG_8: value = 4'h8;
            SEG_9: value = 4'h9;
`ifdef HEX_DECODE_EN
            SEG_A: value = 4'hA;
            SEG_B: value = 4'hB;
            SEG_C: value = 4'hC;
            SEG_D: value = 4'hD;
            SEG_E: value = 4'hE;
            SEG_F: value = 4'hF;
`endif
            default: begin
                valid = 1'b0;
                value = 4'hF;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: receive-side monitor for a multiplexed 4-digit
// 7-segment bus. Synchronizes the bus, waits for each scan pattern to hold
// STABLE_CYCLES samples, decodes the digit and publishes complete frames.
//   clk           in  : system clock
//   Reset_n       in  : asynchronous active-low reset
//   bus (slave)       : Anode_Activate/LED_out/err_clr in;
//                       digits/digit_valid/frame_valid/anode_err/scan_stalled out
// Parameters: STABLE_CYCLES (>=2), TIMEOUT_CYCLES.
// Build option HEX_DECODE_EN (in seg7_glyph_decode) enables hex glyphs.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
)(
    input  logic                     clk,
    input  logic                     Reset_n,
    seven_seg_scan_decoder_if.slave  bus
);

    localparam int SW = $clog2(STABLE_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_HIT = SW'(STABLE_CYCLES);
    // Counter parks one above the hit value so a long hold yields one event.
    localparam logic [SW-1:0] STAB_SAT = SW'(STABLE_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    logic [3:0]    an_p0, an_p1;
    logic [6:0]    seg_p0, seg_p1;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          stable, accept, bad_an, timeout_hit;
    logic [1:0]    acc_idx;
    logic [3:0]    acc_bit;
    logic          glyph_valid;
    logic [3:0]    glyph_value;
    logic [15:0]   digits_q;
    logic [3:0]    digit_valid_q;
    logic          anode_err_q;
    state_t        state_q, state_nxt;
    logic [3:0]    seen_q, seen_nxt;
    logic          frame_q, frame_nxt;
    logic          stalled;

    // ---- p0/p1: two-flop synchronizer; p1 is the working sample ----
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            an_p0  <= AN_BLANK;
            seg_p0 <= 7'h7F;
            an_p1  <= AN_BLANK;
            seg_p1 <= 7'h7F;
        end else begin
            an_p0  <= bus.Anode_Activate;
            seg_p0 <= bus.LED_out;
            an_p1  <= an_p0;
            seg_p1 <= seg_p0;
        end
    end

    // stab_cnt is the run length of the sample currently in p1: compare the
    // incoming p0 value with p1 so the count moves in step with p1.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stab_cnt <= SW'(1);
        end else if ({an_p0, seg_p0} != {an_p1, seg_p1}) begin
            stab_cnt <= SW'(1);
        end else if (stab_cnt != STAB_SAT) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // ---- classification of the stable sample ----
    assign stable  = (stab_cnt == STAB_HIT);
    assign accept  = stable && an_is_onehot_low(an_p1);
    assign bad_an  = stable && (an_p1 != AN_BLANK) && !an_is_onehot_low(an_p1);
    assign acc_idx = an_index(an_p1);
    assign acc_bit = 4'b0001 << acc_idx;

    seg7_glyph_decode u_glyph (
        .seg   (seg_p1),
        .valid (glyph_valid),
        .value (glyph_value)
    );

    // ---- digit, validity and error registers ----
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            digits_q      <= '0;
            digit_valid_q <= '0;
            anode_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                digits_q[{acc_idx, 2'b00} +: 4] <= glyph_value;
                digit_valid_q[acc_idx]          <= glyph_valid;
            end
            // A new error outranks a clear arriving on the same edge.
            if (bad_an) begin
                anode_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                anode_err_q <= 1'b0;
            end
        end
    end

    // Timeout counter: cycles since the last accepted digit, saturating.
    always_comb begin
        if (accept) begin
            tmo_nxt = '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_nxt = tmo_cnt + 1'b1;
        end else begin
            tmo_nxt = tmo_cnt;
        end
    end

    // Stall is entered on the edge where the counter reaches the limit.
    assign timeout_hit = (tmo_nxt == TMO_MAX);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_nxt;
        end
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_SYNC;
            seen_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            seen_q  <= seen_nxt;
            frame_q <= frame_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state_q;
        seen_nxt  = seen_q;
        frame_nxt = 1'b0;
        case (state_q)
            S_SYNC, S_STALL: begin
                if (accept) begin
                    state_nxt = S_COLLECT;
                    seen_nxt  = acc_bit;
                end else begin
                    seen_nxt  = '0;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    // Frame pulse is registered together with the digit, so
                    // the completing digit is visible during the pulse.
                    if ((seen_q | acc_bit) == 4'hF) begin
                        frame_nxt = 1'b1;
                        seen_nxt  = '0;
                    end else begin
                        seen_nxt  = seen_q | acc_bit;
                    end
                end
            end
            default: begin
                state_nxt = S_SYNC;
                seen_nxt  = '0;
            end
        endcase
        if (!accept && timeout_hit) begin
            state_nxt = S_STALL;
            seen_nxt  = '0;
        end
    end

    // ---- FSM: outputs ----
    always_comb begin
        stalled = (state_q == S_STALL);
    end

    assign bus.digits       = digits_q;
    assign bus.digit_valid  = digit_valid_q;
    assign bus.frame_valid  = frame_q;
    assign bus.anode_err    = anode_err_q;
    assign bus.scan_stalled = stalled;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: directed scenarios plus randomized scan traffic
// checked against a transaction-level model of the display monitor.
module tb_seven_seg_scan_decoder;

    localparam int STABLE = 16;
    localparam int TMO    = 100;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seven_seg_scan_decoder_if bus();

    seven_seg_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] frame_log [$];
    always @(negedge clk) if (bus.frame_valid === 1'b1) frame_log.push_back(bus.digits);

    // ---------------- reference model ----------------
    logic [6:0]  glyph [16];
    int          n_legal;
    logic [3:0]  m_dig [4];
    logic        m_dv  [4];
    bit          m_seen [4];
    bit          m_err;
    int          m_last_acc;
    logic [15:0] m_frames [$];

    function automatic void decode(input logic [6:0] p, output logic [3:0] v, output logic ok);
        v  = 4'hF;
        ok = 1'b0;
        for (int i = 0; i < n_legal; i++) begin
            if (glyph[i] == p) begin
                v  = 4'(i);
                ok = 1'b1;
                break;
            end
        end
    endfunction

    function automatic void model_reset(input int now);
        for (int i = 0; i < 4; i++) begin
            m_dig[i]  = 4'h0;
            m_dv[i]   = 1'b0;
            m_seen[i] = 1'b0;
        end
        m_err      = 1'b0;
        m_last_acc = now;
    endfunction

    // A held pattern counts once if it survived STABLE samples; it takes
    // effect two synchronizer cycles plus STABLE plus one register edge later.
    function automatic void model_hold(input logic [3:0] an, input logic [6:0] seg,
                                       input int c0, input int len);
        int t;
        int idx;
        logic [3:0] v;
        logic ok;
        bit full;
        if (len < STABLE || an == 4'hF) return;
        t = c0 + STABLE + 2;
        if ($countones(~an) != 1) begin
            m_err = 1'b1;
            return;
        end
        idx = 0;
        for (int i = 0; i < 4; i++) if (an[i] == 1'b0) idx = i;
        if (t - m_last_acc > TMO) for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        decode(seg, v, ok);
        m_dig[idx]  = v;
        m_dv[idx]   = ok;
        m_seen[idx] = 1'b1;
        full = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
        if (full) begin
            m_frames.push_back({m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        end
        m_last_acc = t;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int len);
        int c0;
        c0 = cyc;
        bus.Anode_Activate = an;
        bus.LED_out        = seg;
        repeat (len) @(negedge clk);
        model_hold(an, seg, c0, len);
    endtask

    task automatic tail(input bit clr);
        bus.Anode_Activate = 4'hF;
        bus.LED_out        = 7'h7F;
        repeat (3) @(negedge clk);
        if (clr) begin
            bus.err_clr = 1'b1;
            @(negedge clk);
            bus.err_clr = 1'b0;
            m_err = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] ed;
        logic [3:0]  ev;
        ed = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        ev = {m_dv[3], m_dv[2], m_dv[1], m_dv[0]};
        chk({tag, "_digits"}, bus.digits, ed);
        chk({tag, "_dvalid"}, bus.digit_valid, ev);
        chk({tag, "_anerr"}, bus.anode_err, m_err);
        chk({tag, "_stall"}, bus.scan_stalled, (cyc - m_last_acc >= TMO));
        chk({tag, "_fvalid"}, bus.frame_valid, 1'b0);
        chk({tag, "_nframes"}, frame_log.size(), m_frames.size());
        if (frame_log.size() == m_frames.size() && frame_log.size() > 0)
            chk({tag, "_framedig"}, frame_log[$], m_frames[$]);
    endtask

    function automatic logic [3:0] onehot_an(input int idx);
        logic [3:0] one;
        one = 4'b0001 << idx;
        return ~one;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int nf;
        int c0;
        int r;
        logic [3:0] an;
        logic [6:0] seg;
        int len;

        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010;
        glyph[3]  = 7'b0000110; glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
        glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0000100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000;
        glyph[15] = 7'b0111000;
`ifdef HEX_DECODE_EN
        n_legal = 16;
`else
        n_legal = 10;
`endif

        rst_n              = 1'b0;
        bus.Anode_Activate = 4'hF;
        bus.LED_out        = 7'h7F;
        bus.err_clr        = 1'b0;
        model_reset(0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_digits", bus.digits, 16'h0);
        chk("rst_dvalid", bus.digit_valid, 4'h0);
        chk("rst_fvalid", bus.frame_valid, 1'b0);
        chk("rst_anerr", bus.anode_err, 1'b0);
        chk("rst_stall", bus.scan_stalled, 1'b0);
        rst_n = 1'b1;
        model_reset(cyc);

        // 1: a full scan produces one frame
        drive(4'hE, glyph[1], 20);
        drive(4'hD, glyph[2], 20);
        drive(4'hB, glyph[3], 20);
        drive(4'h7, glyph[4], 20);
        tail(1'b0);
        check_all("t1");
        chk("t1_frames_const", frame_log.size(), 1);
        chk("t1_digits_const", bus.digits, 16'h4321);
        chk("t1_dvalid_const", bus.digit_valid, 4'hF);

        // 2: 15-sample hold is not enough, 16 is
        drive(4'hE, glyph[0], 15);
        drive(4'hE, glyph[8], 10);
        tail(1'b0);
        check_all("t2a");
        chk("t2a_d0", bus.digits[3:0], 4'h1);
        drive(4'hE, glyph[0], 16);
        tail(1'b0);
        check_all("t2b");
        chk("t2b_d0", bus.digits[3:0], 4'h0);

        // 3: multi-anode error, clear, and set winning over clear
        drive(4'hC, glyph[5], 16);
        tail(1'b0);
        check_all("t3a");
        chk("t3a_err_const", bus.anode_err, 1'b1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_err = 1'b0;
        chk("t3_cleared", bus.anode_err, 1'b0);
        c0 = cyc;
        bus.Anode_Activate = 4'hC;
        bus.LED_out        = glyph[6];
        repeat (STABLE + 1) @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        model_hold(4'hC, glyph[6], c0, STABLE + 2);
        chk("t3_set_wins", bus.anode_err, 1'b1);
        tail(1'b0);
        check_all("t3b");

        // 4: scan stops -> stall exactly TMO cycles after last accept
        bus.Anode_Activate = 4'hF;
        bus.LED_out        = 7'h7F;
        while (cyc < m_last_acc + TMO - 1) @(negedge clk);
        chk("t4_not_yet", bus.scan_stalled, 1'b0);
        @(negedge clk);
        chk("t4_stalled", bus.scan_stalled, 1'b1);
        check_all("t4a");
        drive(4'hB, glyph[7], 16);
        tail(1'b0);
        chk("t4_released", bus.scan_stalled, 1'b0);
        check_all("t4b");
        nf = frame_log.size();
        drive(4'h7, glyph[9], 18);
        drive(4'hD, glyph[2], 18);
        tail(1'b0);
        check_all("t4c");
        chk("t4_no_early_frame", frame_log.size(), nf);
        drive(4'hE, glyph[0], 18);
        tail(1'b0);
        check_all("t4d");
        chk("t4_frame", frame_log.size(), nf + 1);

        // 5: hex glyph 'A' on digit 2
        drive(4'hB, 7'b0001000, 16);
        tail(1'b0);
        check_all("t5");
`ifdef HEX_DECODE_EN
        chk("t5_d2", bus.digits[11:8], 4'hA);
        chk("t5_dv2", bus.digit_valid[2], 1'b1);
`else
        chk("t5_d2", bus.digits[11:8], 4'hF);
        chk("t5_dv2", bus.digit_valid[2], 1'b0);
`endif

        // 6: reset mid-frame discards the partial frame
        drive(4'hE, glyph[3], 16);
        drive(4'hD, glyph[4], 16);
        tail(1'b0);
        nf = frame_log.size();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_digits", bus.digits, 16'h0);
        chk("t6_rst_dvalid", bus.digit_valid, 4'h0);
        rst_n = 1'b1;
        model_reset(cyc);
        drive(4'hB, glyph[5], 16);
        drive(4'h7, glyph[6], 16);
        tail(1'b0);
        check_all("t6a");
        chk("t6_no_frame", frame_log.size(), nf);
        drive(4'hE, glyph[7], 16);
        drive(4'hD, glyph[8], 16);
        tail(1'b0);
        check_all("t6b");
        chk("t6_frame", frame_log.size(), nf + 1);

        // Randomized scan traffic
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 7) begin
                an = onehot_an($urandom_range(0, 3));
                if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
                else seg = glyph[$urandom_range(0, n_legal - 1)];
                len = (r == 7) ? $urandom_range(4, 15) : $urandom_range(16, 22);
            end else begin
                an = 4'($urandom);
                while (an == 4'hF || $countones(~an) == 1) an = 4'($urandom);
                seg = 7'($urandom);
                len = $urandom_range(16, 20);
            end
            drive(an, seg, len);
            tail($urandom_range(0, 5) == 0);
            check_all("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
